axi4_rd_host: RTL and testbench

AXI4_RD_HOST -- requirements
Module: axi4_rd_host

---
 rtl/axi4_rd_host.sv | 198 +++++++++++++++++++
 tb/tb_axi4_rd_host.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_host.sv
// axi4_rd_host
// Single-outstanding AXI4 read host. A read command (address, byte count,
// beat size, burst type) is validated, issued as one AR transaction, its R
// beats are forwarded unmodified onto a ready/valid output stream, and a
// one-cycle status pulse reports the worst response seen (or SLVERR when
// the command itself was rejected).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cmd_*                    read command (size = log2 bytes/beat,
//                            burst 0 FIXED / 1 INCR / 2 WRAP)
//   ar*                      AXI4 read-address channel (master side)
//   r*                       AXI4 read-data channel (master side)
//   out_*                    read-data stream towards the consumer
//   sts_valid, sts_resp      completion pulse and accumulated response
module axi4_rd_host #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_addr,
  input  logic [15:0]       cmd_bytes,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  output logic [ID_W-1:0]   arid,
  output logic [31:0]       araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  output logic              arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic [3:0]        arregion,
  output logic [3:0]        arqos,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sts_valid,
  output logic [1:0]        sts_resp
);

  localparam logic [1:0]  RESP_OKAY   = 2'd0;
  localparam logic [1:0]  RESP_SLVERR = 2'd2;
  localparam logic [16:0] BUS_BYTES   = 17'(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, STS} state_e;

  state_e state_q, state_d;

  logic [ID_W-1:0] arid_q;
  logic [31:0]     araddr_q;
  logic [7:0]      arlen_q;
  logic [2:0]      arsize_q;
  logic [1:0]      arburst_q;
  logic [7:0]      beatCnt_q;
  logic [1:0]      resp_q, resp_d;

  logic [16:0]     bytesPerBeat;
  logic [16:0]     beats;
  logic            cmdOk;
  logic            accept;
  logic            arHs;
  logic            rHs;
  logic [ID_W-1:0] issuedId;

  assign accept = cmd_valid && cmd_ready;
  assign arHs   = arvalid && arready;
  assign rHs    = rvalid && rready;

  // arid_q already advanced on the AR handshake, so the ID of the
  // transaction in flight is one behind it.
  assign issuedId = arid_q - ID_W'(1);

  // Validate the command straight from the inputs so the accept cycle
  // already knows whether to issue AR or go directly to the reject status.
  always_comb begin : cmdCheck
    bytesPerBeat = 17'd1 << cmd_size;
    beats        = (17'(cmd_bytes) + bytesPerBeat - 17'd1) >> cmd_size;
    cmdOk        = 1'b1;
    if (cmd_bytes == 16'd0)                                cmdOk = 1'b0;
    if (beats > 17'd256)                                   cmdOk = 1'b0;
    if (bytesPerBeat > BUS_BYTES)                          cmdOk = 1'b0;
    if (cmd_burst == 2'd3)                                 cmdOk = 1'b0;
    if ((cmd_addr & (32'(bytesPerBeat) - 32'd1)) != 32'd0) cmdOk = 1'b0;
    if ((cmd_burst == 2'd2) &&
        !((beats == 17'd2) || (beats == 17'd4) ||
          (beats == 17'd8) || (beats == 17'd16)))          cmdOk = 1'b0;
    if ((cmd_burst == 2'd0) && (beats > 17'd16))           cmdOk = 1'b0;
  end

  // Response merge for the current beat: worst of accumulated and rresp,
  // raised to at least SLVERR on an ID mismatch or an rlast that does not
  // line up with beat arlen.
  always_comb begin : respMerge
    resp_d = resp_q;
    if (rresp > resp_d) resp_d = rresp;
    if ((rid != issuedId) && (resp_d < RESP_SLVERR)) resp_d = RESP_SLVERR;
    if ((rlast != (beatCnt_q == arlen_q)) && (resp_d < RESP_SLVERR)) resp_d = RESP_SLVERR;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin : nextState
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = cmdOk ? ADDR : STS;
      ADDR:    if (arHs) state_d = DATA;
      DATA:    if (rHs && rlast) state_d = STS;
      STS:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; rst forces them quiet even before the state register
  // has been cleared by the reset edge.
  always_comb begin : fsmOutputs
    cmd_ready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    sts_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: cmd_ready = 1'b1;
        ADDR: arvalid   = 1'b1;
        DATA: begin
          rready    = out_ready;
          out_valid = rvalid;
          out_last  = rlast;
        end
        STS:  sts_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Command registers, ID counter, beat counter and response accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      beatCnt_q <= '0;
      resp_q    <= RESP_OKAY;
    end else begin
      if (accept) begin
        araddr_q  <= cmd_addr;
        arlen_q   <= 8'(beats - 17'd1);
        arsize_q  <= cmd_size;
        arburst_q <= cmd_burst;
        resp_q    <= cmdOk ? RESP_OKAY : RESP_SLVERR;
      end
      if (arHs) begin
        arid_q    <= arid_q + ID_W'(1);
        beatCnt_q <= '0;
      end
      if (rHs) begin
        beatCnt_q <= beatCnt_q + 8'd1;
        resp_q    <= resp_d;
      end
    end
  end

  assign arid     = rst ? '0 : arid_q;
  assign araddr   = rst ? '0 : araddr_q;
  assign arlen    = rst ? '0 : arlen_q;
  assign arsize   = rst ? '0 : arsize_q;
  assign arburst  = rst ? '0 : arburst_q;
  assign sts_resp = rst ? '0 : resp_q;
  assign out_data = rdata;

  assign arlock   = 1'b0;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;
  assign arregion = 4'd0;
  assign arqos    = 4'd0;

endmodule

// File: tb/tb_axi4_rd_host.sv
// tb_axi4_rd_host
// Self-checking bench for axi4_rd_host: a table of commands with hand-derived
// results, hand-written multi-cycle corner sequences, and randomized commands
// whose expectations come from a behavioural model of the command rules and
// the response-accumulation rules.
module tb_axi4_rd_host;

  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [31:0]       cmd_addr;
  logic [15:0]       cmd_bytes;
  logic [2:0]        cmd_size;
  logic [1:0]        cmd_burst;
  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arregion;
  logic [3:0]        arqos;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;
  logic              sts_valid;
  logic [1:0]        sts_resp;

  axi4_rd_host #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_bytes(cmd_bytes), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arregion(arregion), .arqos(arqos),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready),
    .sts_valid(sts_valid), .sts_resp(sts_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the design wedges.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [15:0] bytes;
    logic [2:0]  size;
    logic [1:0]  burst;
    bit          expOk;
    logic [7:0]  expLen;
  } vec_t;

  int passCnt  = 0;
  int totalCnt = 0;

  logic [ID_W-1:0] expId;

  // Beats the slave will return for the next command; rlast goes on the last.
  logic [1:0] qResp[$];
  bit         qRidBad[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passCnt++;
  endtask

  // Command rules: beat count by ceiling division, then every reject rule.
  function automatic void refCmd(input logic [31:0] a, input int bytes, input int size,
                                 input int burst, output bit ok, output logic [7:0] len);
    int bpb;
    int nb;
    bpb = 1 << size;
    nb  = (bytes + bpb - 1) / bpb;
    ok  = 1'b1;
    if (bytes == 0) ok = 1'b0;
    if (nb > 256) ok = 1'b0;
    if (bpb > DATA_W / 8) ok = 1'b0;
    if (burst == 3) ok = 1'b0;
    if ((int'(a[7:0]) % bpb) != 0) ok = 1'b0;
    if (burst == 2 && !(nb == 2 || nb == 4 || nb == 8 || nb == 16)) ok = 1'b0;
    if (burst == 0 && nb > 16) ok = 1'b0;
    len = 8'(nb - 1);
  endfunction

  // Status the slave's planned beats should produce for a burst of len+1 beats.
  function automatic logic [1:0] refResp(input logic [7:0] len);
    int r;
    r = 0;
    foreach (qResp[i]) begin
      if (int'(qResp[i]) > r) r = int'(qResp[i]);
      if (qRidBad[i] && r < 2) r = 2;
    end
    if (qResp.size() != int'(len) + 1 && r < 2) r = 2;
    return 2'(r);
  endfunction

  function automatic void fillOkay(input int n);
    qResp.delete();
    qRidBad.delete();
    for (int i = 0; i < n; i++) begin
      qResp.push_back(2'd0);
      qRidBad.push_back(1'b0);
    end
  endfunction

  // Runs one command end to end. readyMode: 0 out_ready high, 1 toggling
  // starting low, 2 random. expRespIn < 0 takes the status from the model.
  task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] bytes,
                               input logic [2:0] size, input logic [1:0] burst,
                               input bit expOk, input logic [7:0] expLen,
                               input int arDelay, input int readyMode,
                               input int expRespIn, input string tag);
    logic [1:0]      expResp;
    logic [ID_W-1:0] txId;
    int              idx;
    int              guard;
    bit              rdy;
    bit              tog;
    @(negedge clk);
    checkOutput({tag, ":cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_bytes = bytes;
    cmd_size  = size;
    cmd_burst = burst;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_bytes = 16'($urandom);
    cmd_size  = 3'($urandom);
    cmd_burst = 2'($urandom);
    if (!expOk) begin
      checkOutput({tag, ":rej_arvalid"}, arvalid, 0);
      checkOutput({tag, ":rej_sts_valid"}, sts_valid, 1);
      checkOutput({tag, ":rej_sts_resp"}, sts_resp, 2);
      @(negedge clk);
      checkOutput({tag, ":rej_sts_done"}, sts_valid, 0);
      checkOutput({tag, ":rej_idle"}, cmd_ready, 1);
      return;
    end
    checkOutput({tag, ":arvalid"}, arvalid, 1);
    checkOutput({tag, ":araddr"}, araddr, addr);
    checkOutput({tag, ":arlen"}, arlen, expLen);
    checkOutput({tag, ":arsize"}, arsize, size);
    checkOutput({tag, ":arburst"}, arburst, burst);
    checkOutput({tag, ":arid"}, arid, expId);
    for (int i = 0; i < arDelay; i++) begin
      @(negedge clk);
      checkOutput({tag, ":ar_hold_valid"}, arvalid, 1);
      checkOutput({tag, ":ar_hold_addr"}, araddr, addr);
      checkOutput({tag, ":ar_hold_len"}, arlen, expLen);
      checkOutput({tag, ":ar_hold_id"}, arid, expId);
    end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    txId  = expId;
    expId = expId + 1'b1;
    checkOutput({tag, ":ar_done"}, arvalid, 0);
    expResp = (expRespIn < 0) ? refResp(expLen) : 2'(expRespIn);
    idx   = 0;
    guard = 0;
    tog   = 1'b0;
    while (idx < qResp.size() && guard < 2000) begin
      rvalid = 1'b1;
      rdata  = DATA_W'($urandom);
      rid    = qRidBad[idx] ? (txId ^ ID_W'(1)) : txId;
      rresp  = qResp[idx];
      rlast  = (idx == qResp.size() - 1);
      case (readyMode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = ~tog; end
        default: rdy = 1'($urandom);
      endcase
      out_ready = rdy;
      #1;
      checkOutput({tag, ":out_valid"}, out_valid, 1);
      checkOutput({tag, ":out_data"}, out_data, rdata);
      checkOutput({tag, ":out_last"}, out_last, rlast);
      checkOutput({tag, ":rready"}, rready, rdy);
      @(negedge clk);
      if (rdy) idx++;
      guard++;
    end
    rvalid    = 1'b0;
    rlast     = 1'b0;
    out_ready = 1'b1;
    if (guard >= 2000)
      checkOutput({tag, ":beat_timeout"}, 1, 0);
    #1;
    checkOutput({tag, ":sts_valid"}, sts_valid, 1);
    checkOutput({tag, ":sts_resp"}, sts_resp, expResp);
    checkOutput({tag, ":sts_out_valid"}, out_valid, 0);
    @(negedge clk);
    checkOutput({tag, ":sts_done"}, sts_valid, 0);
    checkOutput({tag, ":back_idle"}, cmd_ready, 1);
  endtask

  vec_t vecs[13];

  initial begin
    bit          ok;
    logic [7:0]  len;
    logic [31:0] a;
    int          bpb;
    int          sz;
    int          bs;
    int          bb;
    int          n;
    int          r;

    vecs[0]  = '{32'h0000_0100, 16'd16,   3'd2, 2'd1, 1'b1, 8'd3};
    vecs[1]  = '{32'h0000_0000, 16'd10,   3'd2, 2'd1, 1'b1, 8'd2};
    vecs[2]  = '{32'h0000_0000, 16'd0,    3'd2, 2'd1, 1'b0, 8'd0};
    vecs[3]  = '{32'h0000_0102, 16'd4,    3'd2, 2'd1, 1'b0, 8'd0};
    vecs[4]  = '{32'h0000_0000, 16'd2048, 3'd2, 2'd1, 1'b0, 8'd0};
    vecs[5]  = '{32'h0000_0040, 16'd1024, 3'd2, 2'd1, 1'b1, 8'd255};
    vecs[6]  = '{32'h0000_0000, 16'd8,    3'd3, 2'd1, 1'b0, 8'd0};
    vecs[7]  = '{32'h0000_0000, 16'd16,   3'd2, 2'd3, 1'b0, 8'd0};
    vecs[8]  = '{32'h0000_0000, 16'd12,   3'd2, 2'd2, 1'b0, 8'd0};
    vecs[9]  = '{32'h0000_0020, 16'd32,   3'd2, 2'd2, 1'b1, 8'd7};
    vecs[10] = '{32'h0000_0000, 16'd68,   3'd2, 2'd0, 1'b0, 8'd0};
    vecs[11] = '{32'h0000_0000, 16'd64,   3'd2, 2'd0, 1'b1, 8'd15};
    vecs[12] = '{32'h0000_0012, 16'd5,    3'd1, 2'd1, 1'b1, 8'd2};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_bytes = '0;
    cmd_size  = '0;
    cmd_burst = '0;
    arready   = 1'b0;
    rid       = '0;
    rdata     = '0;
    rresp     = '0;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    out_ready = 1'b1;
    expId     = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst:cmd_ready", cmd_ready, 0);
    checkOutput("rst:arvalid", arvalid, 0);
    checkOutput("rst:sts_valid", sts_valid, 0);
    checkOutput("rst:arid", arid, 0);
    checkOutput("rst:araddr", araddr, 0);
    checkOutput("rst:sts_resp", sts_resp, 0);
    checkOutput("rst:tieoffs", {arlock, arcache, arprot, arregion, arqos}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst:cmd_ready_after", cmd_ready, 1);
    checkOutput("rst:rready_after", rready, 0);

    // Table of commands, slave answers OKAY with exactly arlen+1 beats.
    for (int v = 0; v < 13; v++) begin
      fillOkay(int'(vecs[v].expLen) + 1);
      applyStimulus(vecs[v].addr, vecs[v].bytes, vecs[v].size, vecs[v].burst,
                    vecs[v].expOk, vecs[v].expLen, 0, 0, 0, $sformatf("vec%0d", v));
    end

    // SLVERR on beat 2, DECERR on beat 3 -> DECERR.
    qResp = '{2'd0, 2'd2, 2'd3, 2'd0};
    qRidBad = '{1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(32'h300, 16'd16, 3'd2, 2'd1, 1'b1, 8'd3, 0, 0, 3, "worstResp");

    // rlast on beat 2 of a 4-beat burst -> ends early with SLVERR.
    fillOkay(2);
    applyStimulus(32'h400, 16'd16, 3'd2, 2'd1, 1'b1, 8'd3, 0, 0, 2, "earlyLast");

    // Beat arlen arrives without rlast -> SLVERR.
    fillOkay(5);
    applyStimulus(32'h500, 16'd16, 3'd2, 2'd1, 1'b1, 8'd3, 0, 0, 2, "lateLast");

    // Wrong rid on one beat -> SLVERR, EXOKAY elsewhere does not mask it.
    qResp = '{2'd1, 2'd0, 2'd1};
    qRidBad = '{1'b0, 1'b1, 1'b0};
    applyStimulus(32'h600, 16'd12, 3'd2, 2'd1, 1'b1, 8'd2, 0, 0, 2, "badRid");

    // Reset during DATA: abandon without status, ignore stray R beats.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h200;
    cmd_bytes = 16'd16;
    cmd_size  = 3'd2;
    cmd_burst = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    arready   = 1'b1;
    checkOutput("rstMid:arvalid", arvalid, 1);
    @(negedge clk);
    arready   = 1'b0;
    rvalid    = 1'b1;
    rid       = expId;
    rdata     = DATA_W'($urandom);
    rresp     = 2'd0;
    rlast     = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("rstMid:out_valid", out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstMid:rready_in_rst", rready, 0);
    checkOutput("rstMid:out_valid_in_rst", out_valid, 0);
    checkOutput("rstMid:cmd_ready_in_rst", cmd_ready, 0);
    checkOutput("rstMid:sts_valid_in_rst", sts_valid, 0);
    @(negedge clk);
    checkOutput("rstMid:arid", arid, 0);
    checkOutput("rstMid:araddr", araddr, 0);
    checkOutput("rstMid:arlen", arlen, 0);
    checkOutput("rstMid:sts_resp", sts_resp, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstMid:cmd_ready_after", cmd_ready, 1);
    checkOutput("rstMid:rready_after", rready, 0);
    checkOutput("rstMid:out_valid_after", out_valid, 0);
    checkOutput("rstMid:sts_valid_after", sts_valid, 0);
    rvalid = 1'b0;
    expId  = '0;
    fillOkay(4);
    applyStimulus(32'h100, 16'd16, 3'd2, 2'd1, 1'b1, 8'd3, 0, 0, 0, "afterRst");

    // arready held low 5 cycles, out_ready toggling; arid now 1.
    fillOkay(4);
    applyStimulus(32'h700, 16'd16, 3'd2, 2'd1, 1'b1, 8'd3, 5, 1, 0, "arStall");

    // Randomized commands checked against the reference model.
    for (int t = 0; t < 40; t++) begin
      sz = $urandom_range(0, 3);
      bpb = 1 << sz;
      r = $urandom_range(0, 7);
      bb = (r < 4) ? 1 : (r < 6) ? 2 : (r == 6) ? 0 : 3;
      bs = $urandom_range(0, 64);
      a = $urandom & 32'hFFFF_FFF0;
      if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
      refCmd(a, bs, sz, bb, ok, len);
      qResp.delete();
      qRidBad.delete();
      if (ok) begin
        n = int'(len) + 1;
        r = $urandom_range(0, 9);
        if (r == 0) n = n + 1;
        else if (r == 1 && n > 1) n = n - 1;
        for (int i = 0; i < n; i++) begin
          qResp.push_back(($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'd0);
          qRidBad.push_back($urandom_range(0, 15) == 0);
        end
      end
      applyStimulus(a, 16'(bs), 3'(sz), 2'(bb), ok, len,
                    $urandom_range(0, 3), $urandom_range(0, 2), -1,
                    $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
